// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the memory-stage load/store unit: access sizes,
// writeback select codes, FSM states and the access legality rule.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10
    } wb_sel_t;

    typedef enum logic [1:0] {
        LSU_IDLE     = 2'b00,
        LSU_REQ      = 2'b01,
        LSU_WAIT_RSP = 2'b10
    } lsu_state_t;

    // Illegal size for the direction, or a half/word not naturally aligned.
    function automatic logic access_fault(input logic is_store, input logic [2:0] f3,
                                          input logic [1:0] off);
        logic illegal;
        logic misaligned;
        if (is_store)
            illegal = !(f3 inside {F3_B, F3_H, F3_W});
        else
            illegal = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        misaligned = ((f3[1:0] == 2'b01) && off[0]) ||
                     ((f3[1:0] == 2'b10) && (off != 2'b00));
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends it.
module load_align_ext
    import riscv_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_BU:   data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_H:    data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_HU:   data = {{(XLEN-16){1'b0}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory stage: issues one word-aligned bus access per load/store, holds the
// pipeline until the response, then registers the writeback into MEM/WB.
module mem_stage_lsu
    import riscv_mem_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic [XLEN-1:0]       ex_alu_result,
    input  logic [XLEN-1:0]       ex_write_data,
    input  logic                  ex_data_write_en,
    input  logic                  ex_data_read_en,
    input  logic [2:0]            ex_funct3,
    input  logic                  ex_reg_write,
    input  logic [1:0]            ex_wb_sel,
    input  logic [XLEN-1:0]       ex_pc_plus_four,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_stall,
    output logic                  dbus_req_valid,
    input  logic                  dbus_req_ready,
    output logic [XLEN-1:0]       dbus_addr,
    output logic                  dbus_we,
    output logic [3:0]            dbus_wstrb,
    output logic [XLEN-1:0]       dbus_wdata,
    input  logic                  dbus_rsp_valid,
    input  logic [XLEN-1:0]       dbus_rdata,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic                  misalign_fault,
    output lsu_state_t            state_dbg
);

    // Bus handshake: a request transfers on the rising edge where
    // dbus_req_valid && dbus_req_ready; address/we/wstrb/wdata are held
    // stable from valid until that edge. One dbus_rsp_valid pulse completes
    // the access and is only honoured in WAIT_RSP.
    lsu_state_t state;
    logic [2:0] req_funct3;
    logic [1:0] req_off;

    logic            mem_op;
    logic            is_store;
    logic            fault;
    logic [3:0]      store_strb;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wb_value;

    assign state_dbg = state;
    assign mem_op    = ex_valid & (ex_data_write_en | ex_data_read_en);
    assign is_store  = ex_data_write_en;
    assign fault     = access_fault(is_store, ex_funct3, ex_alu_result[1:0]);

    always_comb begin
        store_strb = 4'b0000;
        store_data = ex_write_data;
        if (is_store) begin
            case (ex_funct3[1:0])
                2'b00: begin
                    store_strb = 4'b0001 << ex_alu_result[1:0];
                    store_data = {(XLEN/8){ex_write_data[7:0]}};
                end
                2'b01: begin
                    store_strb = ex_alu_result[1] ? 4'b1100 : 4'b0011;
                    store_data = {(XLEN/16){ex_write_data[15:0]}};
                end
                default: store_strb = 4'b1111;
            endcase
        end
    end

    load_align_ext #(.XLEN(XLEN)) u_align (
        .rdata   (dbus_rdata),
        .addr_lo (req_off),
        .funct3  (req_funct3),
        .data    (load_data)
    );

    always_comb begin
        case (ex_wb_sel)
            WB_ALU:  wb_value = ex_alu_result;
            WB_LOAD: wb_value = load_data;
            WB_PC4:  wb_value = ex_pc_plus_four;
            default: wb_value = '0;
        endcase
    end

    // The response cycle releases the stall so upstream advances on the same edge.
    always_comb begin
        case (state)
            LSU_IDLE:     mem_stall = mem_op & ~fault;
            LSU_REQ:      mem_stall = 1'b1;
            LSU_WAIT_RSP: mem_stall = ~dbus_rsp_valid;
            default:      mem_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= LSU_IDLE;
            req_funct3     <= 3'b000;
            req_off        <= 2'b00;
            dbus_req_valid <= 1'b0;
            dbus_addr      <= '0;
            dbus_we        <= 1'b0;
            dbus_wstrb     <= 4'b0000;
            dbus_wdata     <= '0;
            wb_valid       <= 1'b0;
            wb_reg_write   <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
            misalign_fault <= 1'b0;
        end else begin
            misalign_fault <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (mem_op && fault) begin
                        misalign_fault <= 1'b1;
                        wb_valid       <= 1'b1;
                        wb_reg_write   <= 1'b0;
                        wb_rd          <= ex_rd;
                        wb_data        <= '0;
                    end else if (mem_op) begin
                        dbus_req_valid <= 1'b1;
                        dbus_addr      <= {ex_alu_result[XLEN-1:2], 2'b00};
                        dbus_we        <= is_store;
                        dbus_wstrb     <= store_strb;
                        dbus_wdata     <= store_data;
                        req_funct3     <= ex_funct3;
                        req_off        <= ex_alu_result[1:0];
                        wb_valid       <= 1'b0;
                        wb_reg_write   <= 1'b0;
                        state          <= LSU_REQ;
                    end else begin
                        wb_valid     <= ex_valid;
                        wb_reg_write <= ex_valid & ex_reg_write;
                        wb_rd        <= ex_rd;
                        wb_data      <= wb_value;
                    end
                end
                LSU_REQ: begin
                    wb_valid     <= 1'b0;
                    wb_reg_write <= 1'b0;
                    if (dbus_req_ready) begin
                        dbus_req_valid <= 1'b0;
                        state          <= LSU_WAIT_RSP;
                    end
                end
                LSU_WAIT_RSP: begin
                    if (dbus_rsp_valid) begin
                        wb_valid     <= 1'b1;
                        wb_reg_write <= ex_reg_write;
                        wb_rd        <= ex_rd;
                        wb_data      <= wb_value;
                        state        <= LSU_IDLE;
                    end else begin
                        wb_valid     <= 1'b0;
                        wb_reg_write <= 1'b0;
                    end
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed scenarios plus a randomized mix checked
// against a size/offset arithmetic model of RV32I load/store behaviour.
module tb_mem_stage_lsu;
    import riscv_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_write_data;
    logic        ex_data_write_en;
    logic        ex_data_read_en;
    logic [2:0]  ex_funct3;
    logic        ex_reg_write;
    logic [1:0]  ex_wb_sel;
    logic [31:0] ex_pc_plus_four;
    logic [4:0]  ex_rd;
    logic        mem_stall;
    logic        dbus_req_valid;
    logic        dbus_req_ready;
    logic [31:0] dbus_addr;
    logic        dbus_we;
    logic [3:0]  dbus_wstrb;
    logic [31:0] dbus_wdata;
    logic        dbus_rsp_valid;
    logic [31:0] dbus_rdata;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_fault;
    lsu_state_t  state_dbg;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_write_data(ex_write_data), .ex_data_write_en(ex_data_write_en),
        .ex_data_read_en(ex_data_read_en), .ex_funct3(ex_funct3), .ex_reg_write(ex_reg_write),
        .ex_wb_sel(ex_wb_sel), .ex_pc_plus_four(ex_pc_plus_four), .ex_rd(ex_rd),
        .mem_stall(mem_stall), .dbus_req_valid(dbus_req_valid), .dbus_req_ready(dbus_req_ready),
        .dbus_addr(dbus_addr), .dbus_we(dbus_we), .dbus_wstrb(dbus_wstrb), .dbus_wdata(dbus_wdata),
        .dbus_rsp_valid(dbus_rsp_valid), .dbus_rdata(dbus_rdata), .wb_valid(wb_valid),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign_fault(misalign_fault), .state_dbg(state_dbg)
    );

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit m_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        return !legal || ((a % m_size(f3)) != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * (a % 4));
        case (f3)
            3'd0: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v + 32'hFFFF_FF00; end
            3'd4: v = v & 32'hFF;
            3'd1: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v + 32'hFFFF_0000; end
            3'd5: v = v & 32'hFFFF;
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = m_size(f3);
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (m_size(f3) == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (m_size(f3) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_wb(input logic [1:0] sel, input logic [31:0] alu,
                                         input logic [31:0] pc4, input logic [31:0] ld);
        case (sel)
            2'd0: return alu;
            2'd1: return ld;
            2'd2: return pc4;
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ex_valid = 0; ex_alu_result = 0; ex_write_data = 0; ex_data_write_en = 0;
        ex_data_read_en = 0; ex_funct3 = 0; ex_reg_write = 0; ex_wb_sel = 0;
        ex_pc_plus_four = 0; ex_rd = 0; dbus_req_ready = 0; dbus_rsp_valid = 0; dbus_rdata = 0;
    endtask

    task automatic drive_op(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                            input logic we, input logic re, input logic [2:0] f3,
                            input logic rw, input logic [1:0] sel, input logic [31:0] pc4,
                            input logic [4:0] rd);
        ex_valid = v; ex_alu_result = alu; ex_write_data = wd; ex_data_write_en = we;
        ex_data_read_en = re; ex_funct3 = f3; ex_reg_write = rw; ex_wb_sel = sel;
        ex_pc_plus_four = pc4; ex_rd = rd;
    endtask

    // Plays the bus side of one access; returns what was observed.
    task automatic bus_txn(input int rdy_dly, input int rsp_dly, input logic [31:0] rdata,
                           output logic [31:0] o_addr, output logic o_we,
                           output logic [3:0] o_strb, output logic [31:0] o_wdata,
                           output bit o_stable, output int o_stalls, output int o_lat,
                           output bit o_bubble, output bit o_timeout);
        bit seen, hs, hs_now, rsp_now;
        int rdy_cnt, rsp_cnt;
        seen = 0; hs = 0; rdy_cnt = 0; rsp_cnt = 0;
        o_addr = 0; o_we = 0; o_strb = 0; o_wdata = 0;
        o_stable = 1; o_stalls = 0; o_lat = 0; o_bubble = 1; o_timeout = 1;
        for (int cyc = 0; cyc < 64; cyc++) begin
            hs_now = 0; rsp_now = 0;
            dbus_req_ready = 0; dbus_rsp_valid = 0;
            if (hs) begin
                if (rsp_cnt >= rsp_dly) begin
                    dbus_rsp_valid = 1; dbus_rdata = rdata; rsp_now = 1;
                end else begin
                    rsp_cnt++; dbus_rdata = $urandom;
                end
            end else if (dbus_req_valid) begin
                if (!seen) begin
                    o_addr = dbus_addr; o_we = dbus_we; o_strb = dbus_wstrb; o_wdata = dbus_wdata;
                end else if (dbus_addr !== o_addr || dbus_we !== o_we ||
                             dbus_wstrb !== o_strb || dbus_wdata !== o_wdata) begin
                    o_stable = 0;
                end
                seen = 1;
                if (rdy_cnt >= rdy_dly) begin
                    dbus_req_ready = 1; hs_now = 1;
                end else begin
                    rdy_cnt++;
                    dbus_rsp_valid = 1; dbus_rdata = $urandom;  // stray response, must be ignored
                end
            end
            #1;
            if (mem_stall) o_stalls++;
            if (cyc > 0 && wb_valid) o_bubble = 0;
            @(posedge clk);
            #1;
            dbus_req_ready = 0; dbus_rsp_valid = 0;
            if (hs_now) hs = 1;
            if (rsp_now) begin
                o_lat = cyc + 1; o_timeout = 0; ex_valid = 0;
                break;
            end
        end
        if (o_timeout) ex_valid = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL reset_wb_reg_write got=%b exp=0", wb_reg_write); end
        checks++; if (wb_data !== 32'd0 || wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb_data got=%h/%0d exp=0/0", wb_data, wb_rd); end
        checks++; if (dbus_req_valid !== 1'b0 || dbus_addr !== 32'd0 || dbus_wstrb !== 4'd0 || dbus_we !== 1'b0 || dbus_wdata !== 32'd0) begin errors++; $display("FAIL reset_dbus got=%b %h %b %b %h exp=all zero", dbus_req_valid, dbus_addr, dbus_wstrb, dbus_we, dbus_wdata); end
        checks++; if (misalign_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", misalign_fault); end
        checks++; if (state_dbg !== LSU_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, LSU_IDLE); end
        reset = 0;
        tick();
    endtask

    task automatic test_alu;
        drive_op(1, 32'h1234_5678, 0, 0, 0, 0, 1, 2'b00, 32'h40, 5'd5);
        #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL alu_stall got=%b exp=0", mem_stall); end
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b1) begin errors++; $display("FAIL alu_valid got=%b/%b exp=1/1", wb_valid, wb_reg_write); end
        checks++; if (wb_data !== 32'h1234_5678) begin errors++; $display("FAIL alu_data got=%h exp=12345678", wb_data); end
        checks++; if (wb_rd !== 5'd5) begin errors++; $display("FAIL alu_rd got=%0d exp=5", wb_rd); end
        ex_valid = 0;
        tick();
    endtask

    task automatic test_lb_lbu;
        logic [31:0] a, wd; logic we; logic [3:0] st; bit stable, bub, to; int stalls, lat;
        logic [2:0] f3s[2];
        logic [31:0] exps[2];
        f3s[0] = F3_B;  exps[0] = 32'hFFFF_FF80;
        f3s[1] = F3_BU; exps[1] = 32'h0000_0080;
        for (int i = 0; i < 2; i++) begin
            drive_op(1, 32'h1003, 0, 0, 1, f3s[i], 1, 2'b01, 0, 5'd7);
            bus_txn(0, 0, 32'h80FF_0000, a, we, st, wd, stable, stalls, lat, bub, to);
            checks++; if (to) begin errors++; $display("FAIL lb_timeout got=timeout exp=response"); end
            checks++; if (a !== 32'h1000 || we !== 1'b0) begin errors++; $display("FAIL lb_req got=%h/%b exp=00001000/0", a, we); end
            checks++; if (stalls != 2) begin errors++; $display("FAIL lb_stall_cycles got=%0d exp=2", stalls); end
            checks++; if (lat != 3) begin errors++; $display("FAIL lb_latency got=%0d exp=3", lat); end
            checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b1 || wb_rd !== 5'd7) begin errors++; $display("FAIL lb_wb got=%b/%b/%0d exp=1/1/7", wb_valid, wb_reg_write, wb_rd); end
            checks++; if (wb_data !== exps[i]) begin errors++; $display("FAIL lb_data f3=%0d got=%h exp=%h", f3s[i], wb_data, exps[i]); end
        end
        tick();
    endtask

    task automatic test_sh_backpressure;
        logic [31:0] a, wd; logic we; logic [3:0] st; bit stable, bub, to; int stalls, lat;
        drive_op(1, 32'h2002, 32'hAAAA_BEEF, 1, 0, F3_H, 0, 2'b00, 0, 5'd0);
        bus_txn(3, 0, 32'h0, a, we, st, wd, stable, stalls, lat, bub, to);
        checks++; if (to) begin errors++; $display("FAIL sh_timeout got=timeout exp=response"); end
        checks++; if (a !== 32'h2000 || we !== 1'b1) begin errors++; $display("FAIL sh_req got=%h/%b exp=00002000/1", a, we); end
        checks++; if (st !== 4'b1100 || wd !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_lanes got=%b/%h exp=1100/beefbeef", st, wd); end
        checks++; if (!stable) begin errors++; $display("FAIL sh_stable got=changed exp=stable"); end
        checks++; if (stalls != 5 || lat != 6) begin errors++; $display("FAIL sh_timing got=stall%0d/lat%0d exp=stall5/lat6", stalls, lat); end
        checks++; if (!bub) begin errors++; $display("FAIL sh_bubble got=wb_valid during stall exp=0"); end
        checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin errors++; $display("FAIL sh_wb got=%b/%b exp=1/0", wb_valid, wb_reg_write); end
        tick();
    endtask

    task automatic test_misalign;
        bit req_seen;
        req_seen = 0;
        drive_op(1, 32'h3001, 0, 0, 1, F3_W, 1, 2'b01, 0, 5'd9);
        #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL mis_stall got=%b exp=0", mem_stall); end
        tick();
        if (dbus_req_valid) req_seen = 1;
        checks++; if (misalign_fault !== 1'b1) begin errors++; $display("FAIL mis_pulse got=%b exp=1", misalign_fault); end
        checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin errors++; $display("FAIL mis_wb got=%b/%b exp=1/0", wb_valid, wb_reg_write); end
        drive_op(1, 32'h3000, 0, 1, 0, 3'b100, 0, 2'b00, 0, 5'd0);  // store with a load-only size
        tick();
        if (dbus_req_valid) req_seen = 1;
        checks++; if (misalign_fault !== 1'b1) begin errors++; $display("FAIL illegal_store_pulse got=%b exp=1", misalign_fault); end
        ex_valid = 0;
        tick();
        if (dbus_req_valid) req_seen = 1;
        checks++; if (misalign_fault !== 1'b0) begin errors++; $display("FAIL mis_one_cycle got=%b exp=0", misalign_fault); end
        checks++; if (req_seen) begin errors++; $display("FAIL mis_no_req got=req_valid exp=none"); end
    endtask

    task automatic test_reset_mid;
        drive_op(1, 32'h4000, 0, 0, 1, F3_W, 1, 2'b01, 0, 5'd3);
        tick();
        dbus_req_ready = 1;
        tick();
        dbus_req_ready = 0;
        checks++; if (state_dbg !== LSU_WAIT_RSP) begin errors++; $display("FAIL rmid_state got=%0d exp=%0d", state_dbg, LSU_WAIT_RSP); end
        #2;
        reset = 1;
        ex_valid = 0;
        #1;
        checks++; if (state_dbg !== LSU_IDLE || wb_valid !== 1'b0 || dbus_req_valid !== 1'b0) begin errors++; $display("FAIL rmid_async got=%0d/%b/%b exp=0/0/0", state_dbg, wb_valid, dbus_req_valid); end
        tick();
        reset = 0;
        dbus_rsp_valid = 1; dbus_rdata = 32'hCAFE_F00D;
        #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rmid_stall got=%b exp=0", mem_stall); end
        tick();
        dbus_rsp_valid = 0;
        checks++; if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0 || state_dbg !== LSU_IDLE) begin errors++; $display("FAIL rmid_late_rsp got=%b/%b/%0d exp=0/0/0", wb_valid, wb_reg_write, state_dbg); end
    endtask

    task automatic test_jal_bubble;
        drive_op(1, 32'hDEAD_0000, 0, 0, 0, 0, 1, 2'b10, 32'h0000_0104, 5'd1);
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h104 || wb_rd !== 5'd1) begin errors++; $display("FAIL jal_wb got=%b/%h/%0d exp=1/00000104/1", wb_valid, wb_data, wb_rd); end
        drive_op(0, 32'h55, 0, 0, 0, 0, 1, 2'b00, 0, 5'd2);
        tick();
        checks++; if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0) begin errors++; $display("FAIL bubble_wb got=%b/%b exp=0/0", wb_valid, wb_reg_write); end
    endtask

    task automatic test_random_mix;
        logic [31:0] a, wd, alu, wdat, rdat, pc4, exp_v; logic we; logic [3:0] st;
        bit stable, bub, to; int stalls, lat, kind, rdy, rsp, sz; logic [2:0] f3; logic [4:0] rd;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 4);
            alu = $urandom; wdat = $urandom; rdat = $urandom; pc4 = $urandom & 32'hFFFF_FFFC;
            rd = 5'($urandom_range(1, 31));
            rdy = $urandom_range(0, 2); rsp = $urandom_range(0, 2);
            if (kind <= 1) begin
                drive_op(1, alu, 0, 0, 0, 0, 1, kind[0] ? 2'b10 : 2'b00, pc4, rd);
                exp_q.push_back(m_wb(kind[0] ? 2'b10 : 2'b00, alu, pc4, 0));
                tick();
                exp_v = exp_q.pop_front();
                checks++; if (wb_valid !== 1'b1 || wb_data !== exp_v || wb_rd !== rd) begin errors++; $display("FAIL rnd_alu n=%0d got=%b/%h/%0d exp=1/%h/%0d", n, wb_valid, wb_data, wb_rd, exp_v, rd); end
            end else if (kind == 4) begin
                case ($urandom_range(0, 3))
                    0: f3 = 3'd1;
                    1: f3 = 3'd2;
                    2: f3 = 3'd5;
                    default: f3 = 3'd3;
                endcase
                sz = m_size(f3);
                a = (f3 == 3'd3) ? (alu & ~32'd3) : ((alu & ~32'(sz - 1)) | 32'd1);
                drive_op(1, a, wdat, 0, 1, f3, 1, 2'b01, 0, rd);
                #1;
                checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rnd_fault_stall n=%0d got=%b exp=0", n, mem_stall); end
                tick();
                checks++; if (misalign_fault !== m_fault(0, f3, a) || wb_reg_write !== 1'b0) begin errors++; $display("FAIL rnd_fault n=%0d got=%b/%b exp=1/0", n, misalign_fault, wb_reg_write); end
                ex_valid = 0;
            end else begin
                if (kind == 2) begin
                    case ($urandom_range(0, 4))
                        0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
                    endcase
                end else begin
                    f3 = 3'($urandom_range(0, 2));
                end
                a = alu & ~32'(m_size(f3) - 1);
                if (kind == 2) begin
                    drive_op(1, a, wdat, 0, 1, f3, 1, 2'b01, pc4, rd);
                    exp_q.push_back(m_load(f3, a, rdat));
                end else begin
                    drive_op(1, a, wdat, 1, $urandom_range(0, 1), f3, 0, 2'b00, pc4, rd);
                    exp_q.push_back(a);
                end
                bus_txn(rdy, rsp, rdat, a, we, st, wd, stable, stalls, lat, bub, to);
                exp_v = exp_q.pop_front();
                checks++; if (to || lat != 3 + rdy + rsp || stalls != 2 + rdy + rsp) begin errors++; $display("FAIL rnd_timing n=%0d got=to%0d/lat%0d/stall%0d exp=lat%0d", n, to, lat, stalls, 3 + rdy + rsp); end
                checks++; if (a !== (ex_alu_result & ~32'd3) || we !== (kind == 3)) begin errors++; $display("FAIL rnd_req n=%0d got=%h/%b exp=%h/%0d", n, a, we, ex_alu_result & ~32'd3, kind == 3); end
                if (kind == 3) begin
                    checks++; if (st !== m_strb(f3, ex_alu_result) || wd !== m_wdata(f3, wdat)) begin errors++; $display("FAIL rnd_store n=%0d got=%b/%h exp=%b/%h", n, st, wd, m_strb(f3, ex_alu_result), m_wdata(f3, wdat)); end
                end
                checks++; if (!stable || !bub) begin errors++; $display("FAIL rnd_hold n=%0d got=stable%0d/bubble%0d exp=1/1", n, stable, bub); end
                checks++; if (wb_valid !== 1'b1 || wb_data !== exp_v || wb_reg_write !== (kind == 2)) begin errors++; $display("FAIL rnd_wb n=%0d f3=%0d got=%b/%h/%b exp=1/%h/%0d", n, f3, wb_valid, wb_data, wb_reg_write, exp_v, kind == 2); end
            end
        end
        ex_valid = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lb_lbu();
        test_sh_backpressure();
        test_misalign();
        test_reset_mid();
        test_jal_bubble();
        test_random_mix();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory-stage load/store unit that consumes the EX/MEM pipeline register outputs: ALU result, store data, write enable and writeback select. It issues word-aligned requests on a valid/ready data bus, aligns and extends load data, and selects the writeback value. Results are registered into MEM/WB outputs. The block stalls the upstream pipeline while a bus transaction is outstanding.

Parameters:
XLEN, 32, datapath and address width
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
ex_valid  in  1  an instruction is present in EX/MEM
ex_alu_result  in  XLEN  ALU result / effective address
ex_write_data  in  XLEN  store source data
ex_data_write_en  in  1  store
ex_data_read_en  in  1  load
ex_funct3  in  3  access size/sign (RV32I encoding)
ex_reg_write  in  1  instruction writes rd
ex_wb_sel  in  2  00 ALU, 01 load, 10 pc+4, 11 reserved
ex_pc_plus_four  in  XLEN  link value
ex_rd  in  REG_ADDR_W  destination register
mem_stall  out  1  upstream must hold EX/MEM contents
dbus_req_valid  out  1  request valid
dbus_req_ready  in  1  bus accepts request
dbus_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
dbus_we  out  1  1 = store
dbus_wstrb  out  4  byte enables
dbus_wdata  out  XLEN  lane-replicated store data
dbus_rsp_valid  in  1  response (loads and stores)
dbus_rdata  in  XLEN  load word
wb_valid  out  1  MEM/WB entry valid
wb_reg_write  out  1  write rd
wb_rd  out  REG_ADDR_W  destination
wb_data  out  XLEN  writeback value
misalign_fault  out  1  one-cycle pulse on a misaligned or illegal access

Behaviour:
- Reset, asynchronous: state IDLE; all registered outputs 0 (wb_*, dbus_req_valid, dbus_addr/wdata/wstrb/we, misalign_fault).
- mem op = ex_valid & (ex_data_write_en | ex_data_read_en). If both enables are set, the access is a store.
- Legal sizes: loads use funct3 000/001/010/100/101; stores use 000/001/010. Any other funct3, or a misaligned access (half with addr[0]=1, word with addr[1:0]!=0), is a fault.
- FSM states: IDLE, REQ, WAIT_RSP.
- IDLE, non-mem op or bubble: no stall. At the next edge wb_* load; latency 1. wb_valid=ex_valid, wb_reg_write=ex_valid&ex_reg_write. wb_data: 00 ALU, 10 pc+4, 11 gives 0.
- IDLE, faulting mem op: no bus access, no stall. Next edge: misalign_fault=1 for 1 cycle, wb_valid=1, wb_reg_write=0.
- IDLE, legal mem op: mem_stall=1 combinationally. Capture addr, we, wstrb, wdata and funct3 into request registers, then go to REQ. wb_valid=0 at that edge.
- REQ: dbus_req_valid=1 and stall=1. Request fields stay stable until dbus_req_ready. Handshake edge moves to WAIT_RSP and drops req_valid.
- WAIT_RSP: stall=1 until the dbus_rsp_valid cycle. In that cycle stall=0 (upstream advances at the same edge), and wb_* load with wb_valid=1 and wb_reg_write=ex_reg_write. Return to IDLE.
- dbus_rsp_valid is ignored in IDLE and REQ. Minimum mem-op latency is 3 cycles from presentation to wb_valid.
- Store lanes: SB wstrb=1<<addr[1:0], wdata={4{byte}}. SH wstrb=0011 or 1100, wdata={2{half}}. SW wstrb=1111.
- Load: extract by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. wb_sel=01 selects the result.
- During stall wb_valid=0 (bubble to WB). Upstream holds ex_* stable while mem_stall=1.
- Reset mid-transaction abandons the access. A late response after reset is ignored.

Decomposition:
- Package riscv_mem_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - wb_sel enum (WB_ALU, WB_LOAD, WB_PC4)
  - lsu_state_t enum
- Sub-module load_align_ext: combinational byte/half extraction and sign/zero extension (rdata, addr[1:0], funct3 -> XLEN).

Test Plan:
- ALU op: ex_alu_result=0x12345678, wb_sel=00, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_data=0x12345678, wb_rd=5, no stall.
- LB: addr=0x1003, rdata=0x80FF_0000 returned with ready and rsp immediate -> dbus_addr=0x1000, stall for 2 cycles, wb_data=0xFFFFFF80. Repeat as LBU -> 0x00000080.
- SH: addr=0x2002, write_data=0xAAAA_BEEF -> wstrb=1100, wdata=0xBEEFBEEF, dbus_we=1. Hold ready=0 for 3 cycles -> request fields stable, stall held.
- LW at addr=0x3001 -> misalign_fault pulse, wb_reg_write=0, dbus_req_valid never asserted, mem_stall=0.
- Assert reset in WAIT_RSP, then rsp_valid after release -> state IDLE, wb_valid=0, response ignored.
- JAL link: wb_sel=10, pc_plus_four=0x0000_0104 -> wb_data=0x104. Bubble (ex_valid=0) -> wb_valid=0, wb_reg_write=0.
